// File: rtl/v74x139_pkg.sv
// Shared types and slot-search helper for the v74x139 scan sequencer.
package v74x139_pkg;

  localparam int SLOT_W    = 2;
  localparam int NUM_SLOTS = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_BLANK  = 2'd2
  } state_e;

  typedef struct packed {
    logic [SLOT_W-1:0] idx;
    logic              wrap;
  } slot_pick_t;

  // Next set mask bit after cur, searching cyclically; wrap flags idx <= cur.
  // An empty mask returns cur with wrap set.
  function automatic slot_pick_t next_slot(input logic [SLOT_W-1:0] cur,
                                           input logic [NUM_SLOTS-1:0] mask);
    slot_pick_t        r;
    logic [SLOT_W-1:0] cand;
    logic              found;
    r.idx  = cur;
    r.wrap = 1'b1;
    found  = 1'b0;
    for (int i = 1; i <= NUM_SLOTS; i++) begin
      cand = cur + SLOT_W'(i);
      if (!found && mask[cand]) begin
        r.idx  = cand;
        r.wrap = (cand <= cur);
        found  = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/v74x139_scan_seq_slot_pick.sv
// Combinational next-enabled-slot search with wrap detection.
module v74x139_slot_pick
  import v74x139_pkg::*;
(
  input  logic [SLOT_W-1:0]    cur_i,
  input  logic [NUM_SLOTS-1:0] mask_i,
  output logic [SLOT_W-1:0]    idx_o,
  output logic                 wrap_o,
  output logic                 any_o
);

  slot_pick_t pick;

  always_comb begin
    pick = next_slot(cur_i, mask_i);
  end

  assign idx_o  = pick.idx;
  assign wrap_o = pick.wrap;
  assign any_o  = |mask_i;

endmodule

// File: rtl/v74x139_scan_seq.sv
// Round-robin scan controller driving G_L/A/B of a 74x139 half-decoder,
// with programmable dwell, fixed blanking gap and slot/frame pulses.
module v74x139_scan_seq
  import v74x139_pkg::*;
#(
  parameter int DWELL_W      = 8,
  parameter int BLANK_CYCLES = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               EN,
  input  logic               ONESHOT,
  input  logic [DWELL_W-1:0] DWELL,
  input  logic [3:0]         MASK,
  output logic               G_L,
  output logic               A,
  output logic               B,
  output logic               SLOT_DONE,
  output logic               FRAME_DONE,
  output logic               BUSY,
  output logic [1:0]         dbg_state_o
);

  localparam logic [3:0] BLANK_LOAD = 4'(BLANK_CYCLES - 1);

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [3:0]          mask_q, mask_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [DWELL_W-1:0]  dcnt_q, dcnt_d;
  logic [3:0]          bcnt_q, bcnt_d;
  logic                stop_q, stop_d;
  logic                wrap_q, wrap_d;
  logic                gl_q, gl_d;
  logic                busy_q, busy_d;
  logic                sd_q, sd_d;
  logic                fd_q, fd_d;

  logic [SLOT_W-1:0]   nxt_idx, first_idx;
  logic                nxt_wrap, first_wrap, nxt_any, first_any;
  logic [DWELL_W-1:0]  dwell_in;

  // Walking from slot 3 makes the search start at 0, i.e. the lowest set bit.
  v74x139_slot_pick u_pick_next (
    .cur_i  (slot_q),
    .mask_i (mask_q),
    .idx_o  (nxt_idx),
    .wrap_o (nxt_wrap),
    .any_o  (nxt_any)
  );

  v74x139_slot_pick u_pick_first (
    .cur_i  (2'd3),
    .mask_i (MASK),
    .idx_o  (first_idx),
    .wrap_o (first_wrap),
    .any_o  (first_any)
  );

  // Counters hold "cycles remaining minus one", so DWELL=0 and DWELL=1 coincide.
  assign dwell_in = (DWELL == '0) ? '0 : DWELL - DWELL_W'(1);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    dcnt_d  = dcnt_q;
    bcnt_d  = bcnt_q;
    stop_d  = stop_q;
    wrap_d  = wrap_q;
    sd_d    = 1'b0;
    fd_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (EN && first_any) begin
          state_d = ST_ACTIVE;
          slot_d  = first_idx;
          mask_d  = MASK;
          dwell_d = dwell_in;
          dcnt_d  = dwell_in;
          stop_d  = 1'b0;
        end
      end

      ST_ACTIVE: begin
        if (!EN) stop_d = 1'b1;
        if (dcnt_q == '0) begin
          state_d = ST_BLANK;
          bcnt_d  = BLANK_LOAD;
          sd_d    = 1'b1;
          fd_d    = nxt_wrap;
          wrap_d  = nxt_wrap;
        end else begin
          dcnt_d = dcnt_q - DWELL_W'(1);
        end
      end

      ST_BLANK: begin
        if (bcnt_q != 4'd0) begin
          bcnt_d = bcnt_q - 4'd1;
          if (!EN) stop_d = 1'b1;
        end else if (stop_q || !EN || (ONESHOT && wrap_q)) begin
          state_d = ST_IDLE;
        end else if (wrap_q) begin
          // Frame boundary: pick up fresh MASK/DWELL from the inputs.
          if (first_any) begin
            state_d = ST_ACTIVE;
            slot_d  = first_idx;
            mask_d  = MASK;
            dwell_d = dwell_in;
            dcnt_d  = dwell_in;
            stop_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_ACTIVE;
          slot_d  = nxt_idx;
          dcnt_d  = dwell_q;
          stop_d  = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    gl_d   = (state_d != ST_ACTIVE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      mask_q  <= '0;
      dwell_q <= '0;
      dcnt_q  <= '0;
      bcnt_q  <= '0;
      stop_q  <= 1'b0;
      wrap_q  <= 1'b0;
      gl_q    <= 1'b1;
      busy_q  <= 1'b0;
      sd_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      dcnt_q  <= dcnt_d;
      bcnt_q  <= bcnt_d;
      stop_q  <= stop_d;
      wrap_q  <= wrap_d;
      gl_q    <= gl_d;
      busy_q  <= busy_d;
      sd_q    <= sd_d;
      fd_q    <= fd_d;
    end
  end

  assign G_L         = gl_q;
  assign A           = slot_q[0];
  assign B           = slot_q[1];
  assign SLOT_DONE   = sd_q;
  assign FRAME_DONE  = fd_q;
  assign BUSY        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_v74x139_scan_seq.sv
// Self-checking bench for v74x139_scan_seq: slot records scoreboarded against
// an expected queue, plus per-cycle pulse, select-hold and blank-length checks.
module tb_v74x139_scan_seq;
  import v74x139_pkg::*;

  logic       clk, rst, en, oneshot;
  logic [7:0] dwell;
  logic [3:0] mask;
  logic       g_l, a, b, slot_done, frame_done, busy;
  logic [1:0] dbg;
  logic       g_l3, a3, b3, sd3, fd3, busy3;
  logic [1:0] dbg3;

  int n_checks = 0;
  int n_err    = 0;

  logic [10:0] exp_q[$];  // {frame_done, slot, active_len}

  v74x139_scan_seq #(.DWELL_W(8), .BLANK_CYCLES(1)) dut (
    .CLK(clk), .RESET(rst), .EN(en), .ONESHOT(oneshot), .DWELL(dwell), .MASK(mask),
    .G_L(g_l), .A(a), .B(b), .SLOT_DONE(slot_done), .FRAME_DONE(frame_done),
    .BUSY(busy), .dbg_state_o(dbg)
  );

  v74x139_scan_seq #(.DWELL_W(8), .BLANK_CYCLES(3)) dut3 (
    .CLK(clk), .RESET(rst), .EN(en), .ONESHOT(oneshot), .DWELL(dwell), .MASK(mask),
    .G_L(g_l3), .A(a3), .B(b3), .SLOT_DONE(sd3), .FRAME_DONE(fd3),
    .BUSY(busy3), .dbg_state_o(dbg3)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor for the BLANK_CYCLES=1 instance
  logic       prev_gl = 1'b1;
  logic [1:0] prev_sel = 2'd0;
  logic [1:0] act_sel = 2'd0;
  logic [7:0] act_len = 8'd0;
  logic       seen_slot = 1'b0;
  int         high_cnt = 0;
  int         starts_n = 0;
  int         sd_n = 0;
  int         fd_n = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_gl   <= 1'b1;
      seen_slot <= 1'b0;
      high_cnt  <= 0;
    end else begin
      chk("slot_done_pulse", slot_done, (!prev_gl) && g_l);
      if (!busy) chk("gl_when_idle", g_l, 1'b1);
      if (!prev_gl && !g_l) chk("sel_hold", {b, a}, prev_sel);
      if (prev_gl && !g_l) begin
        starts_n <= starts_n + 1;
        act_len  <= 8'd1;
        act_sel  <= {b, a};
        if (seen_slot) chk("blank_len", high_cnt, 1);
      end else if (!g_l) begin
        act_len <= act_len + 8'd1;
      end
      if (!prev_gl && g_l) begin
        sd_n <= sd_n + 1;
        if (frame_done) fd_n <= fd_n + 1;
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("slot_rec", {frame_done, act_sel, act_len}, exp_q.pop_front());
        seen_slot <= 1'b1;
        high_cnt  <= 1;
      end else begin
        chk("frame_done_pulse", frame_done, 1'b0);
        if (g_l && seen_slot) high_cnt <= high_cnt + 1;
      end
      if (!busy) begin
        seen_slot <= 1'b0;
        high_cnt  <= 0;
      end
      prev_gl  <= g_l;
      prev_sel <= {b, a};
    end
  end

  // Monitor for the BLANK_CYCLES=3 instance
  logic       prev_gl3 = 1'b1;
  logic [1:0] prev_sel3 = 2'd0;
  logic       seen3 = 1'b0;
  int         high3 = 0;
  int         b3_blank_n = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_gl3 <= 1'b1;
      seen3    <= 1'b0;
      high3    <= 0;
    end else begin
      if (!prev_gl3 && !g_l3) chk("b3_sel_hold", {b3, a3}, prev_sel3);
      if (prev_gl3 && !g_l3 && seen3) begin
        chk("b3_blank_len", high3, 3);
        b3_blank_n <= b3_blank_n + 1;
      end
      if (!prev_gl3 && g_l3) begin
        seen3 <= 1'b1;
        high3 <= 1;
      end else if (g_l3 && seen3) begin
        high3 <= high3 + 1;
      end
      if (!busy3) begin
        seen3 <= 1'b0;
        high3 <= 0;
      end
      prev_gl3  <= g_l3;
      prev_sel3 <= {b3, a3};
    end
  end

  // Driver tasks (inputs change 1ns after the falling edge)
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_slots(input logic [3:0] m, input int dw, input int n);
    int cur, nxt, len;
    len = (dw == 0) ? 1 : dw;
    cur = 0;
    while (!m[cur]) cur++;
    for (int k = 0; k < n; k++) begin
      nxt = (cur + 1) % 4;
      while (!m[nxt]) nxt = (nxt + 1) % 4;
      exp_q.push_back({(nxt <= cur), 2'(cur), 8'(len)});
      cur = nxt;
    end
  endtask

  task automatic wait_starts(input int target, input int budget);
    int t = 0;
    while (starts_n < target && t < budget) begin
      step();
      t++;
    end
    if (starts_n < target) chk("timeout_starts", starts_n, target);
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while (busy && t < budget) begin
      step();
      t++;
    end
    if (busy) chk("timeout_idle", busy, 1'b0);
  endtask

  // Scan nslots slots, dropping EN 'extra' cycles into the last one.
  task automatic run_scan(input logic [3:0] m, input logic [7:0] dw, input int nslots,
                          input int extra);
    int base = starts_n;
    push_slots(m, dw, nslots);
    mask = m; dwell = dw; oneshot = 1'b0; en = 1'b1;
    step();
    chk("start_latency", g_l, 1'b0);
    wait_starts(base + nslots, 2000);
    repeat (extra) step();
    en = 1'b0;
    wait_idle(2000);
    chk("queue_drained", exp_q.size(), 0);
    chk("slot_starts", starts_n - base, nslots);
  endtask

  initial begin
    int base, sd0, fd0;
    rst = 1'b1; en = 1'b0; oneshot = 1'b0; dwell = 8'd0; mask = 4'd0;
    repeat (3) step();
    chk("rst_gl", g_l, 1'b1);
    chk("rst_sel", {b, a}, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", dbg, ST_IDLE);
    rst = 1'b0;
    step();
    chk("post_rst_sd", slot_done, 1'b0);
    chk("post_rst_fd", frame_done, 1'b0);

    // Full frame, then masked patterns
    run_scan(4'b1111, 8'd3, 6, 0);
    run_scan(4'b1010, 8'd2, 4, 0);
    run_scan(4'b0100, 8'd2, 3, 0);
    run_scan(4'b1001, 8'd1, 3, 0);

    // Oneshot with DWELL=0
    base = starts_n; sd0 = sd_n; fd0 = fd_n;
    push_slots(4'b1111, 0, 4);
    mask = 4'b1111; dwell = 8'd0; oneshot = 1'b1; en = 1'b1;
    wait_starts(base + 4, 200);
    wait_idle(200);
    en = 1'b0;
    repeat (4) step();
    chk("oneshot_starts", starts_n - base, 4);
    chk("oneshot_sd", sd_n - sd0, 4);
    chk("oneshot_fd", fd_n - fd0, 1);
    chk("oneshot_gl", g_l, 1'b1);
    chk("oneshot_busy", busy, 1'b0);
    chk("oneshot_queue", exp_q.size(), 0);
    oneshot = 1'b0;

    // EN dropped in the second cycle of slot 1
    run_scan(4'b1111, 8'd5, 2, 1);

    // Reset while slot 1 is active
    base = starts_n;
    push_slots(4'b1111, 5, 1);
    mask = 4'b1111; dwell = 8'd5; en = 1'b1;
    wait_starts(base + 2, 200);
    step();
    chk("pre_rst_gl", g_l, 1'b0);
    chk("pre_rst_sel", {b, a}, 2'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_gl", g_l, 1'b1);
    chk("async_rst_sel", {b, a}, 2'd0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_sd", slot_done, 1'b0);
    chk("async_rst_fd", frame_done, 1'b0);
    en = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    chk("rst_queue", exp_q.size(), 0);
    exp_q.delete();

    // EN with an empty mask stays idle
    mask = 4'b0000; dwell = 8'd3; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("mask0_busy", busy, 1'b0);
      chk("mask0_gl", g_l, 1'b1);
    end
    en = 1'b0;
    step();

    chk("b3_blank_seen", b3_blank_n > 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
